// File: rtl/tcp_rx_sched_pkg.sv
// Shared types and helpers for the TCP receive-side read scheduler.
package tcp_rx_sched_pkg;

    localparam int NOTIF_W = 88;
    localparam int RDREQ_W = 32;

    // Notification as carried on s_notif_data (upper 7 bits are padding).
    typedef struct packed {
        logic [6:0]  rsvd;
        logic        closed;
        logic [15:0] dst_port;
        logic [31:0] ip;
        logic [15:0] length;
        logic [15:0] session;
    } notif_t;

    // Read package issued towards the data buffer.
    typedef struct packed {
        logic [15:0] length;
        logic [15:0] session;
    } rd_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2
    } sched_state_e;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/tcp_notif_fifo.sv
// First-word-fall-through notification FIFO. A written entry becomes visible
// on the read side one cycle after the write, while the full flag tracks the
// write pointer immediately so no entry can ever be overwritten.
module tcp_notif_fifo #(
    parameter int WIDTH = 88,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_vis_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = (wr_vis_q == rd_ptr_q);
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign dout_o    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance for accepted pushes and pops.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Storage write; contents need no reset since the empty flag gates reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    // Pointer registers; the visible write pointer lags by one cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            wr_vis_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            wr_vis_q <= wr_ptr_q;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/tcp_rx_read_sched.sv
// Receive-side read scheduler: queues notifications, splits them into reads
// of at most MAX_READ bytes and only issues a read when the downstream buffer
// has byte credit for the whole chunk. Credit returns as beats are drained.
module tcp_rx_read_sched
    import tcp_rx_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 512,
    parameter int NOTIF_DEPTH = 512,
    parameter int BUF_BYTES   = 262144,
    parameter int MAX_READ    = 4096
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              s_notif_valid,
    output logic                              s_notif_ready,
    input  logic [NOTIF_W-1:0]                s_notif_data,
    output logic                              m_read_valid,
    input  logic                              m_read_ready,
    output logic [RDREQ_W-1:0]                m_read_data,
    input  logic                              rx_beat_done,
    input  logic [$clog2(DATA_WIDTH/8):0]     rx_beat_bytes,
    output logic [31:0]                       outstanding_bytes,
    output logic [31:0]                       stat_notif_drop,
    output logic [31:0]                       stat_credit_stall,
    output logic [31:0]                       stat_zero_len
);

    localparam logic [15:0] MAX_READ_W  = 16'(MAX_READ);
    localparam logic [31:0] BUF_BYTES_W = 32'(BUF_BYTES);

    sched_state_e      state_q, state_d;
    logic [15:0]       session_q, session_d;
    logic [15:0]       remaining_q, remaining_d;
    logic              rd_valid_q, rd_valid_d;
    rd_req_t           rd_data_q, rd_data_d;
    logic [31:0]       outstanding_q, outstanding_d;
    logic [31:0]       drop_q, drop_d;
    logic [31:0]       stall_q, stall_d;
    logic [31:0]       zero_q, zero_d;

    logic [NOTIF_W-1:0] fifo_dout_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               fifo_push_s;
    logic               pop_s;
    notif_t             head_s;
    logic [15:0]        chunk_s;
    logic [31:0]        credit_s;
    logic               credit_ok_s;
    logic               rd_hs_s;
    logic [32:0]        sum_s;
    logic [32:0]        sub_s;
    logic               unused_notif_s;

    assign s_notif_ready  = ~fifo_full_s;
    assign fifo_push_s    = s_notif_valid & ~fifo_full_s;
    assign head_s         = notif_t'(fifo_dout_s);
    assign unused_notif_s = ^{head_s.rsvd, head_s.closed, head_s.dst_port, head_s.ip};

    tcp_notif_fifo #(
        .WIDTH (NOTIF_W),
        .DEPTH (NOTIF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (fifo_push_s),
        .din_i   (s_notif_data),
        .pop_i   (pop_s),
        .dout_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Chunk size and credit are derived from registered state only.
    always_comb begin
        chunk_s = remaining_q;
        if (remaining_q > MAX_READ_W) begin
            chunk_s = MAX_READ_W;
        end else begin
            chunk_s = remaining_q;
        end
        credit_s = 32'd0;
        if (outstanding_q >= BUF_BYTES_W) begin
            credit_s = 32'd0;
        end else begin
            credit_s = BUF_BYTES_W - outstanding_q;
        end
        credit_ok_s = (credit_s >= {16'd0, chunk_s});
        rd_hs_s     = rd_valid_q & m_read_ready;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s && (head_s.length != 16'd0)) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (credit_ok_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_ISSUE: begin
                if (m_read_ready) begin
                    if (remaining_q == rd_data_q.length) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next values (request, credit, statistics).
    always_comb begin
        pop_s       = 1'b0;
        session_d   = session_q;
        remaining_d = remaining_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        stall_d     = stall_q;
        zero_d      = zero_q;
        drop_d      = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    session_d   = head_s.session;
                    remaining_d = head_s.length;
                    if (head_s.length == 16'd0) begin
                        zero_d = sat_inc32(zero_q);
                    end else begin
                        zero_d = zero_q;
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_CHECK: begin
                if (credit_ok_s) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = '{length: chunk_s, session: session_q};
                end else begin
                    stall_d = sat_inc32(stall_q);
                end
            end
            ST_ISSUE: begin
                if (m_read_ready) begin
                    rd_valid_d  = 1'b0;
                    remaining_d = remaining_q - rd_data_q.length;
                end else begin
                    rd_valid_d = 1'b1;
                end
            end
            default: begin
                rd_valid_d = 1'b0;
            end
        endcase

        if (s_notif_valid && fifo_full_s) begin
            drop_d = sat_inc32(drop_q);
        end else begin
            drop_d = drop_q;
        end

        // Reservation and drain combine; a drain below zero clamps at zero.
        sum_s = 33'(outstanding_q);
        if (rd_hs_s) begin
            sum_s = 33'(outstanding_q) + 33'(rd_data_q.length);
        end else begin
            sum_s = 33'(outstanding_q);
        end
        sub_s = 33'd0;
        if (rx_beat_done) begin
            sub_s = 33'(rx_beat_bytes);
        end else begin
            sub_s = 33'd0;
        end
        outstanding_d = 32'd0;
        if (sum_s < sub_s) begin
            outstanding_d = 32'd0;
        end else begin
            outstanding_d = 32'(sum_s - sub_s);
        end
    end

    // Datapath and statistics registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            session_q     <= 16'd0;
            remaining_q   <= 16'd0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            outstanding_q <= 32'd0;
            drop_q        <= 32'd0;
            stall_q       <= 32'd0;
            zero_q        <= 32'd0;
        end else begin
            session_q     <= session_d;
            remaining_q   <= remaining_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            stall_q       <= stall_d;
            zero_q        <= zero_d;
        end
    end

    assign m_read_valid      = rd_valid_q;
    assign m_read_data       = rd_data_q;
    assign outstanding_bytes = outstanding_q;
    assign stat_notif_drop   = drop_q;
    assign stat_credit_stall = stall_q;
    assign stat_zero_len     = zero_q;

endmodule
